// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam int OPCODE_W   = 7;
  localparam int INSTR_W    = 32;
  localparam int PC_STEP    = 4;
  // PC field of a buffered entry is carried at full 64-bit width.
  localparam int ENTRY_PC_W = 64;

  typedef struct packed {
    logic [INSTR_W-1:0]    instr;
    logic [ENTRY_PC_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush. DEPTH must be a power of two >= 2 so the
// pointers wrap naturally. Push while full is accepted only together with
// a pop; pop while empty is ignored; flush empties the FIFO and wins over
// push/pop in the same cycle.
module fetch_fifo #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  // Storage, pointers and occupancy; flush returns to the empty state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches, buffers the
// returned words in a prefetch FIFO and presents them to decode.
// Optional build macro: FETCH_ALIGN_CHECK_EN (misaligned redirect target
// sets a sticky error and halts fetch until reset).
//
// Handshakes: every channel is valid/ready. A transfer happens on a rising
// edge where both valid and ready are high; a valid source holds its
// payload stable until that edge. resp_valid has no ready: the credit rule
// (outstanding + buffered < FIFO_DEPTH) guarantees every response a slot.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN       = 64,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                req_valid,
  input  logic                req_ready,
  output logic [XLEN-1:0]     req_addr,
  input  logic                resp_valid,
  input  logic [INSTR_W-1:0]  resp_data,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [INSTR_W-1:0]  instr,
  output logic [XLEN-1:0]     instr_pc,
  output logic [OPCODE_W-1:0] op_code,
  input  logic                redirect,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic                misalign_err
);

  localparam int        CW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] CAP = (CW + 1)'(FIFO_DEPTH);

  fetch_state_t    state;
  fetch_state_t    state_next;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] redirect_tgt;
  logic [XLEN-1:0] tag_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   outstanding_next;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   tag_count;
  logic            credit_ok;
  logic            req_fire;
  logic            resp_keep;
  logic            pop_fire;
  logic            align_bad;
  logic            fifo_full;
  logic            fifo_empty;
  logic            tag_full;
  logic            tag_empty;
  fetch_entry_t    entry_in;
  fetch_entry_t    entry_head;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q;

  assign redirect_tgt = redirect_pc;
  assign align_bad    = redirect && (redirect_pc[1:0] != 2'b00);
  assign misalign_err = misalign_q;

  // Sticky misaligned-target flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         misalign_q <= 1'b0;
    else if (align_bad) misalign_q <= 1'b1;
  end
`else
  // Targets are word aligned by construction: drop the low two bits.
  assign redirect_tgt = redirect_pc & ~(XLEN'(3));
  assign align_bad    = 1'b0;
  assign misalign_err = 1'b0;
`endif

  assign credit_ok        = ({1'b0, outstanding} + {1'b0, fifo_count}) < CAP;
  assign req_addr         = pc;
  assign req_fire         = req_valid && req_ready;
  // A response landing in a redirect cycle belongs to the old path.
  assign resp_keep        = resp_valid && (drop == '0) && !redirect;
  assign pop_fire         = instr_valid && instr_ready && !redirect;
  assign outstanding_next = outstanding + CW'(req_fire) - CW'(resp_valid);

  assign instr_valid = !fifo_empty;
  assign instr       = instr_valid ? entry_head.instr : '0;
  assign instr_pc    = instr_valid ? XLEN'(entry_head.pc) : '0;
  assign op_code     = instr[OPCODE_W-1:0];

  // Pair the returned word with the PC it was fetched from.
  always_comb begin
    entry_in       = '0;
    entry_in.instr = resp_data;
    entry_in.pc    = ENTRY_PC_W'(tag_pc);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_next;
  end

  // Next state and request valid; redirect always suppresses a request.
  always_comb begin
    state_next = state;
    req_valid  = 1'b0;
    case (state)
      BOOT:    state_next = align_bad ? HALT : RUN;
      RUN: begin
        req_valid = credit_ok && !redirect;
        if (align_bad) state_next = HALT;
      end
      HALT:    state_next = HALT;
      default: state_next = BOOT;
    endcase
  end

  // PC, in-flight count and stale-response drop count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect) begin
        pc   <= redirect_tgt;
        drop <= outstanding_next;
      end else begin
        if (req_fire) pc <= pc + XLEN'(PC_STEP);
        if (resp_valid && (drop != '0)) drop <= drop - 1'b1;
      end
    end
  end

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_entry_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (resp_keep),
    .push_data (entry_in),
    .pop       (pop_fire),
    .flush     (redirect),
    .head_data (entry_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // PCs of requests whose responses will be kept, in issue order.
  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_fire),
    .push_data (pc),
    .pop       (resp_keep),
    .flush     (redirect),
    .head_data (tag_pc),
    .count     (tag_count),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  a_resp_has_credit: assert property (@(posedge clk) disable iff (!rst_n)
    resp_valid |-> (outstanding != '0));
  a_entry_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (resp_keep && fifo_full) |-> pop_fire);
  a_tag_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    req_fire |-> !tag_full);
  a_tag_available: assert property (@(posedge clk) disable iff (!rst_n)
    resp_keep |-> !tag_empty);
  a_tag_tracks_kept: assert property (@(posedge clk) disable iff (!rst_n)
    tag_count == (outstanding - drop));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table for the basic
// stream, then hand-written sequences for backpressure, redirects,
// PC wrap-around and misaligned targets.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready;
  logic [63:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        instr_valid, instr_ready;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic [6:0]  op_code;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        misalign_err;

  // Second instance: high reset PC, memory never answers.
  logic        req_valid_h, req_ready_h;
  logic [63:0] req_addr_h;
  logic        resp_valid_h;
  logic [31:0] resp_data_h;
  logic        instr_valid_h, instr_ready_h;
  logic [31:0] instr_h;
  logic [63:0] instr_pc_h;
  logic [6:0]  op_code_h;
  logic        redirect_h;
  logic [63:0] redirect_pc_h;
  logic        misalign_h;

  fetch_unit #(.XLEN(64), .RESET_PC(64'h0), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .op_code(op_code),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .misalign_err(misalign_err)
  );

  fetch_unit #(.XLEN(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFF8), .FIFO_DEPTH(4)) dut_hi (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_h), .req_ready(req_ready_h), .req_addr(req_addr_h),
    .resp_valid(resp_valid_h), .resp_data(resp_data_h),
    .instr_valid(instr_valid_h), .instr_ready(instr_ready_h),
    .instr(instr_h), .instr_pc(instr_pc_h), .op_code(op_code_h),
    .redirect(redirect_h), .redirect_pc(redirect_pc_h),
    .misalign_err(misalign_h)
  );

  // Clock and reset: 10-unit period; reset driven by reset_dut.
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          hs_count = 0;
  logic        mem_hold = 1'b0;
  logic [63:0] pend_q[$];
  logic [63:0] hs_addr_q[$];
  logic [63:0] hi_addr_q[$];
  logic [63:0] exp_q[$];

  // Memory contents: opcode field = word index bits a[8:2].
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return {8'hC0, a[17:2], 1'b0, a[8:2]};
  endfunction

  // Memory model, edge side: retire the presented response, log requests.
  always @(posedge clk) begin
    if (resp_valid && pend_q.size() > 0) void'(pend_q.pop_front());
    if (req_valid && req_ready) begin
      pend_q.push_back(req_addr);
      hs_addr_q.push_back(req_addr);
      hs_count <= hs_count + 1;
    end
    if (req_valid_h && req_ready_h) hi_addr_q.push_back(req_addr_h);
  end

  // Memory model, drive side: present the oldest pending word after each edge.
  always begin
    @(posedge clk);
    #3;
    if (rst_n && !mem_hold && pend_q.size() > 0) begin
      resp_valid = 1'b1;
      resp_data  = mem_word(pend_q[0]);
    end else begin
      resp_valid = 1'b0;
      resp_data  = '0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n       = 1'b0;
    resp_valid  = 1'b0;
    resp_data   = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    req_ready   = 1'b0;
    instr_ready = 1'b0;
    mem_hold    = 1'b0;
    pend_q.delete();
    hs_addr_q.delete();
    hi_addr_q.delete();
    hs_count = 0;
    #1;
    chk("rst_req_valid",   64'(req_valid),    64'd0);
    chk("rst_req_addr",    req_addr,          64'd0);
    chk("rst_instr_valid", 64'(instr_valid),  64'd0);
    chk("rst_instr",       64'(instr),        64'd0);
    chk("rst_instr_pc",    instr_pc,          64'd0);
    chk("rst_op_code",     64'(op_code),      64'd0);
    chk("rst_misalign",    64'(misalign_err), 64'd0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_hs(input int n);
    for (int i = 0; i < 20 && hs_count < n; i++) step();
    chk("hs_reach", 64'(hs_count), 64'(n));
  endtask

  // Scoreboard: every delivered head must match the front of exp_q.
  task automatic drain_check(input string name, input int max_cycles);
    logic [63:0] e;
    logic [31:0] w;
    #1;
    for (int i = 0; i < max_cycles && exp_q.size() > 0; i++) begin
      if (instr_valid && instr_ready) begin
        e = exp_q.pop_front();
        w = mem_word(e);
        chk({name, "_pc"},    instr_pc,      e);
        chk({name, "_instr"}, 64'(instr),    64'(w));
        chk({name, "_op"},    64'(op_code),  64'(w[6:0]));
      end
      step();
    end
    chk({name, "_done"}, 64'(exp_q.size()), 64'd0);
  endtask

  typedef struct {
    logic        req_ready;
    logic        instr_ready;
    logic        exp_req_valid;
    logic [63:0] exp_req_addr;
    logic        exp_instr_valid;
    logic [63:0] exp_pc;
  } vec_t;

  vec_t        vecs[7];
  logic [63:0] hi_exp[4];

  initial begin
    logic [31:0] w;

    req_ready_h   = 1'b1;
    resp_valid_h  = 1'b0;
    resp_data_h   = '0;
    instr_ready_h = 1'b0;
    redirect_h    = 1'b0;
    redirect_pc_h = '0;

    // Cycle 0 is BOOT; 1-cycle memory latency puts the first head at cycle 3.
    vecs[0] = '{1'b1, 1'b1, 1'b0, 64'h00, 1'b0, 64'h0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 64'h00, 1'b0, 64'h0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 64'h04, 1'b0, 64'h0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 64'h08, 1'b1, 64'h0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 64'h0C, 1'b1, 64'h4};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 64'h10, 1'b1, 64'h8};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 64'h14, 1'b1, 64'hC};

    hi_exp[0] = 64'hFFFF_FFFF_FFFF_FFF8;
    hi_exp[1] = 64'hFFFF_FFFF_FFFF_FFFC;
    hi_exp[2] = 64'h0;
    hi_exp[3] = 64'h4;

    // Basic streaming from the vector table.
    reset_dut();
    for (int i = 0; i < 7; i++) begin
      if (i > 0) step();
      req_ready   = vecs[i].req_ready;
      instr_ready = vecs[i].instr_ready;
      #1;
      w = vecs[i].exp_instr_valid ? mem_word(vecs[i].exp_pc) : 32'h0;
      chk($sformatf("v%0d_req_valid", i),   64'(req_valid),   64'(vecs[i].exp_req_valid));
      chk($sformatf("v%0d_req_addr", i),    req_addr,         vecs[i].exp_req_addr);
      chk($sformatf("v%0d_instr_valid", i), 64'(instr_valid), 64'(vecs[i].exp_instr_valid));
      chk($sformatf("v%0d_instr_pc", i),    instr_pc,         vecs[i].exp_pc);
      chk($sformatf("v%0d_instr", i),       64'(instr),       64'(w));
      chk($sformatf("v%0d_op_code", i),     64'(op_code),     64'(w[6:0]));
    end

    // Decode stalled: exactly FIFO_DEPTH requests, then drain and resume.
    reset_dut();
    req_ready   = 1'b1;
    instr_ready = 1'b0;
    repeat (12) step();
    chk("stall_hs_count",    64'(hs_count),    64'd4);
    chk("stall_req_valid",   64'(req_valid),   64'd0);
    chk("stall_instr_valid", 64'(instr_valid), 64'd1);
    chk("stall_head_pc",     instr_pc,         64'd0);
    instr_ready = 1'b1;
    exp_q.delete();
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h4);
    exp_q.push_back(64'h8);
    exp_q.push_back(64'hC);
    exp_q.push_back(64'h10);
    drain_check("drain", 30);
    chk("resume_addr", (hs_addr_q.size() > 4) ? hs_addr_q[4] : 64'hDEAD, 64'h10);

    // Redirect with two requests in flight: both responses are dropped.
    reset_dut();
    mem_hold    = 1'b1;
    req_ready   = 1'b1;
    instr_ready = 1'b1;
    wait_hs(2);
    req_ready   = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 64'h100;
    #1;
    chk("redir_req_valid_low", 64'(req_valid), 64'd0);
    step();
    redirect  = 1'b0;
    req_ready = 1'b1;
    mem_hold  = 1'b0;
    #1;
    chk("redir_empty", 64'(instr_valid), 64'd0);
    exp_q.delete();
    exp_q.push_back(64'h100);
    drain_check("redir", 20);

    // Redirect in the same cycle as a response: that response is dropped too.
    reset_dut();
    mem_hold    = 1'b1;
    req_ready   = 1'b1;
    instr_ready = 1'b0;
    wait_hs(2);
    mem_hold = 1'b0;
    step();
    chk("same_hs_count", 64'(hs_count), 64'd3);
    redirect    = 1'b1;
    redirect_pc = 64'h200;
    #1;
    chk("same_resp_present",   64'(resp_valid), 64'd1);
    chk("same_req_valid_low",  64'(req_valid),  64'd0);
    step();
    redirect = 1'b0;
    #1;
    chk("same_dropped", 64'(instr_valid), 64'd0);
    instr_ready = 1'b1;
    exp_q.delete();
    exp_q.push_back(64'h200);
    drain_check("same", 20);

    // Misaligned redirect target.
    reset_dut();
    req_ready   = 1'b1;
    instr_ready = 1'b1;
    repeat (4) step();
    redirect    = 1'b1;
    redirect_pc = 64'h102;
    #1;
    chk("mis_req_valid_low", 64'(req_valid), 64'd0);
    step();
    redirect = 1'b0;
    #1;
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis_err_set", 64'(misalign_err), 64'd1);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("mis_halt_req%0d", i), 64'(req_valid), 64'd0);
      step();
    end
    chk("mis_fifo_empty", 64'(instr_valid),  64'd0);
    chk("mis_err_sticky", 64'(misalign_err), 64'd1);
    reset_dut();
`else
    chk("mis_err_tied", 64'(misalign_err), 64'd0);
    exp_q.delete();
    exp_q.push_back(64'h100);
    drain_check("mis", 20);
`endif

    // PC wrap-around from a high reset PC (second instance).
    reset_dut();
    repeat (8) step();
    chk("hi_count", 64'(hi_addr_q.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("hi_addr%0d", i), (i < hi_addr_q.size()) ? hi_addr_q[i] : 64'hDEAD, hi_exp[i]);
    chk("hi_req_valid",   64'(req_valid_h),   64'd0);
    chk("hi_pc_wrapped",  req_addr_h,         64'h8);
    chk("hi_instr_valid", 64'(instr_valid_h), 64'd0);
    chk("hi_instr",       64'(instr_h),       64'd0);
    chk("hi_instr_pc",    instr_pc_h,         64'd0);
    chk("hi_op_code",     64'(op_code_h),     64'd0);
    chk("hi_misalign",    64'(misalign_h),    64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "time limit");
  end

endmodule
